// File: rtl/wb_scheduler_pkg.sv
// Shared RV32I types: CDB payload and writeback source tags.
// Also holds the round-robin pointer step used by the scheduler.
package rv32i_types;

  typedef struct packed {
    logic        cdb_valid;
    logic [4:0]  rob_index;
    logic [5:0]  pd;
    logic [31:0] data;
  } cdb_t;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MUL = 2'd1,
    SRC_LS  = 2'd2
  } wb_src_t;

  localparam int unsigned NUM_SRC = 3;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback buffer holding CDB payloads.
// Fullness comes from registered count, so full blocks push even on pop.
module wb_fifo
  import rv32i_types::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  cdb_t din,
  input  logic pop,
  output cdb_t head,
  output logic full,
  output logic empty
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  cdb_t          mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Payload storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; flush drops everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_scheduler.sv
// Writeback scheduler: three source FIFOs share one registered CDB.
// Round-robin grant among non-empty heads, one broadcast per cycle.
module wb_scheduler
  import rv32i_types::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    branch_flush,
  input  logic    alu_cdb_valid,
  input  logic    mul_cdb_valid,
  input  logic    ls_cdb_valid,
  input  cdb_t    ALU_cdb,
  input  cdb_t    MUL_cdb,
  input  cdb_t    LS_cdb,
  output logic    alu_cdb_ready,
  output logic    mul_cdb_ready,
  output logic    ls_cdb_ready,
  output cdb_t    cdb,
  output wb_src_t cdb_src,
  output logic    wb_busy
);

  logic [2:0] src_valid;
  logic [2:0] full;
  logic [2:0] empty;
  logic [2:0] pop;
  cdb_t       src_din [NUM_SRC];
  cdb_t       head [NUM_SRC];
  logic [1:0] rr_ptr;
  logic [1:0] cand [NUM_SRC];
  logic [1:0] gnt_idx;
  logic       gnt;

  assign src_valid  = {ls_cdb_valid, mul_cdb_valid, alu_cdb_valid};
  assign src_din[0] = ALU_cdb;
  assign src_din[1] = MUL_cdb;
  assign src_din[2] = LS_cdb;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    wb_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .flush(branch_flush),
      .push (src_valid[i]),
      .din  (src_din[i]),
      .pop  (pop[i]),
      .head (head[i]),
      .full (full[i]),
      .empty(empty[i])
    );
  end

  assign alu_cdb_ready = !full[0];
  assign mul_cdb_ready = !full[1];
  assign ls_cdb_ready  = !full[2];
  assign wb_busy       = !(&empty) || cdb.cdb_valid;

  // Scan heads starting at rr_ptr; first non-empty one wins.
  always_comb begin
    cand[0] = rr_ptr;
    cand[1] = rr_next(rr_ptr);
    cand[2] = rr_next(cand[1]);
    gnt     = 1'b0;
    gnt_idx = rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!gnt && !empty[cand[k]]) begin
        gnt     = 1'b1;
        gnt_idx = cand[k];
      end
    end
  end

  // Dequeue the granted head; the FIFO itself ignores pop on flush.
  always_comb begin
    pop = '0;
    if (gnt) pop[gnt_idx] = 1'b1;
  end

  // Broadcast register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb     <= '0;
      cdb_src <= SRC_ALU;
      rr_ptr  <= 2'd0;
    end else if (branch_flush) begin
      cdb <= '0;
    end else if (gnt) begin
      cdb           <= head[gnt_idx];
      cdb.cdb_valid <= 1'b1;
      cdb_src       <= wb_src_t'(gnt_idx);
      rr_ptr        <= rr_next(gnt_idx);
    end else begin
      cdb.cdb_valid <= 1'b0;
    end
  end

endmodule

// File: doc/wb_scheduler.md
WB_SCHEDULER -- requirements
Module: wb_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning entries per source writeback FIFO; supported values are 2 and 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have port branch_flush, input, 1, synchronous flush of all buffered results.
REQ-005 SHALL have ports alu_cdb_valid / mul_cdb_valid / ls_cdb_valid, input, 1 each, meaning the source presents a result.
REQ-006 SHALL have ports ALU_cdb / MUL_cdb / LS_cdb, input, cdb_t each, meaning the result payload; the embedded cdb_valid field is ignored.
REQ-007 SHALL have ports alu_cdb_ready / mul_cdb_ready / ls_cdb_ready, output, 1 each, meaning the source FIFO can accept.
REQ-008 SHALL have port cdb, output, cdb_t, the registered broadcast; cdb.cdb_valid marks a live broadcast.
REQ-009 SHALL have port cdb_src, output, wb_src_t, the source of the current broadcast, valid only when cdb.cdb_valid is 1.
REQ-010 SHALL have port wb_busy, output, 1, high when any FIFO is non-empty or cdb.cdb_valid is 1.

Function
REQ-011 SHALL accept a source result on a rising edge where its valid and ready are both 1, writing it to that source's FIFO tail.
REQ-012 SHALL drive each ready from registered occupancy only: ready = (count != FIFO_DEPTH); a full FIFO SHALL NOT accept, even when dequeued in the same cycle.
REQ-013 SHALL arbitrate each cycle among the non-empty FIFO heads, round-robin starting at rr_ptr, in order ALU(0), MUL(1), LS(2).
REQ-014 SHALL, on a grant to source i, dequeue that head, register it into cdb with cdb_valid=1 and cdb_src=i, and set rr_ptr to (i+1) mod 3.
REQ-015 SHALL, with no non-empty FIFO, register cdb_valid=0, hold the cdb payload and cdb_src, and leave rr_ptr unchanged.
REQ-016 SHALL provide a latency of 2 edges from acceptance to broadcast: accepted at edge E, visible on cdb after edge E+1, when uncontended.
REQ-017 SHALL grant at most one result per cycle; every accepted result SHALL be broadcast exactly once unless a flush occurs.
REQ-018 SHALL preserve per-source FIFO order; no ordering is guaranteed across sources.
REQ-019 SHALL support simultaneous enqueue and dequeue on a non-full FIFO, leaving count unchanged.
REQ-020 SHALL, on a branch_flush edge, empty all FIFOs, drop any input accepted in that cycle, set cdb to all-zero, and leave rr_ptr unchanged.
REQ-021 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-022 SHALL bound starvation: a non-empty head SHALL be granted within 3 cycles.

Reset
REQ-023 SHALL, while rst=1 and independent of clk, hold all FIFOs empty, rr_ptr=0, cdb all-zero, and cdb_src=SRC_ALU.
REQ-024 SHALL, during reset, drive all three ready outputs to 1 and wb_busy to 0.
REQ-025 SHALL, when reset is asserted mid-operation, discard all buffered results; arbitration resumes from ALU after reset release.

Structure
REQ-026 SHALL take cdb_t from the shared rv32i_types package.
REQ-027 SHALL add wb_src_t to rv32i_types as a 2-bit enum: SRC_ALU=0, SRC_MUL=1, SRC_LS=2.
REQ-028 SHALL implement each source buffer as sub-module wb_fifo with parameter FIFO_DEPTH, instantiated 3 times; it carries a cdb_t payload and provides push, pop, full and empty, plus flush and asynchronous reset.
REQ-029 SHALL keep the round-robin arbiter and the output register in wb_scheduler.

Verification
REQ-030 SHALL cover single source: one ALU push with rob_index=5 -> cdb_valid=1, rob_index=5, cdb_src=SRC_ALU two edges later, for exactly one cycle.
REQ-031 SHALL cover all-contend: ALU, MUL and LS push one result each in the same cycle with rr_ptr=0 -> broadcasts in order ALU, MUL, LS on three consecutive cycles.
REQ-032 SHALL cover backpressure: MUL pushes 3 results while LS holds its FIFO head busy (FIFO_DEPTH=2) -> mul_cdb_ready=0 after the second accept, and no result is lost or duplicated.
REQ-033 SHALL cover flush: 2 ALU and 1 LS results buffered, then branch_flush pulsed with a concurrent MUL push -> the next cycle cdb is all-zero, wb_busy=0, and no later broadcast of those results occurs.
REQ-034 SHALL cover async reset: rst asserted between clock edges with 3 buffered results -> cdb_valid=0 immediately, all ready=1, and the first post-release grant goes to ALU.
REQ-035 SHALL cover random streams: 10k cycles of random valids -> per-source order is preserved, every result is broadcast once, and no head waits more than 3 cycles.
